divergence_ctrl: RTL and testbench
==================================

Name: divergence_ctrl

Overview:
- Control stage directly upstream of the predicate stack (pstack) in the SM core scheduler.
- Takes decoded SIMT branch ops (IF / ELSE / ENDIF) with per-lane condition masks and issues one-cycle push/comp/pop strobes to pstack.
- Reads back the pstack top-of-stack flags and asks the PC unit to jump over a block when no lane is active in it.
- Tracks nesting depth and flags overflow/underflow.

Parameters:
N_CORES, 4, lane count; width of masks (matches `N_CORES)
DEPTH, 8, maximum IF nesting supported by pstack
PC_W, 8, program counter width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  branch op presented
instr_ready  out  1  high when block can accept an op (state IDLE)
op  in  2  0=NONE, 1=IF, 2=ELSE, 3=ENDIF
cond_mask  in  N_CORES  per-lane condition result for IF
skip_pc  in  PC_W  target when block is empty (ELSE addr for IF, ENDIF addr for ELSE)
ps_d  out  N_CORES  mask to pstack d
ps_push  out  1  pstack push strobe
ps_pop  out  1  pstack pop strobe
ps_comp  out  1  pstack complement strobe
ps_q  in  N_CORES  pstack top mask (active lanes)
ps_all_false  in  1  pstack flag: top mask all zero
lane_en  out  N_CORES  active lane mask to datapath (= ps_q when depth>0, all ones when depth==0)
pc_load  out  1  one-cycle request to PC unit to jump
pc_target  out  PC_W  jump address, valid with pc_load
depth  out  log2(DEPTH)+1  current nesting level
err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async): state=IDLE, depth=0, err=0, ps_d=0, ps_push=ps_pop=ps_comp=0, pc_load=0, pc_target=0. lane_en is all ones. pstack shares the same reset.
- Accept: occurs on a rising edge with instr_valid & instr_ready. instr_ready = (state==IDLE). Upstream holds op until accepted. instr_valid while busy is ignored.
- FSM states: IDLE, STROBE, CHECK.
- IF, depth<DEPTH:
  - On accept: ps_d <= cond_mask & lane_en, latch skip_pc, go to STROBE.
  - STROBE: ps_push=1 for exactly one cycle, depth+1, then CHECK.
  - CHECK: if ps_all_false, pc_load=1 and pc_target=latched skip_pc this cycle; then IDLE.
- ELSE, depth>0: STROBE asserts ps_comp for one cycle; CHECK as for IF.
- ENDIF, depth>0: STROBE asserts ps_pop for one cycle, depth-1, then IDLE directly. No CHECK, no pc_load.
- NONE: accepted, no strobe, stays IDLE.
- Op latency: IF/ELSE = 3 cycles from accept edge to instr_ready high again; ENDIF = 2 cycles; NONE = 0 cycles (ready stays high).
- At most one of ps_push/ps_pop/ps_comp is high in any cycle. They are never high outside STROBE.
- Error cases:
  - IF with depth==DEPTH, or ELSE/ENDIF with depth==0: err <= 1. The op is consumed with no strobe and no depth change.
  - err is sticky until reset. The block keeps operating normally after err is set.
- pc_load is only asserted in CHECK and lasts one cycle. pc_target holds its last value otherwise.
- Reset asserted mid-operation (any state): immediate return to reset values. A partially issued strobe is dropped.
- depth never wraps: saturates per the error rules.

Test Plan:
- Reset then IF cond_mask=4'b1010, skip_pc=8'h20 -> push pulse 1 cycle with ps_d=1010; depth=1; no pc_load; lane_en=1010; ready back 3 cycles after accept.
- IF cond_mask=0, skip_pc=8'h30 at depth 1 -> ps_d=0000; pc_load=1 in CHECK with pc_target=8'h30; depth=2.
- ELSE after IF mask 1010 (pstack comp gives 0101) -> ps_comp pulse; no pc_load. ELSE after IF mask 1111 -> comp result 0000, pc_load with skip_pc.
- Nest 8 IFs then a 9th -> err=1, no push, depth stays 8; then 8 ENDIFs -> 8 pop pulses, depth=0, lane_en=1111.
- ENDIF at depth 0 -> err=1, no ps_pop; NONE op -> no strobes, instr_ready stays high.
- Assert reset during STROBE of an IF -> ps_push drops immediately; depth=0, state IDLE, err=0.

Source files
------------

// File: rtl/divergence_ctrl_if.sv
// divergence_ctrl_if: groups the branch-op handshake, the pstack strobe/flag
// bus and the PC-unit jump request of the divergence controller.
//   slave  - the divergence controller itself
//   master - its environment (decoder, pstack, PC unit)
// Signals:
//   instr_valid/instr_ready/op/cond_mask/skip_pc : branch op handshake
//   ps_d/ps_push/ps_pop/ps_comp                  : strobes to pstack
//   ps_q/ps_all_false                            : pstack top-of-stack
//   lane_en                                      : active lanes to datapath
//   pc_load/pc_target                            : jump request to PC unit
//   depth/err                                    : nesting level, sticky error
interface divergence_ctrl_if #(
    parameter int N_CORES = 4,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 8
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic                instr_valid;
    logic                instr_ready;
    logic [1:0]          op;
    logic [N_CORES-1:0]  cond_mask;
    logic [PC_W-1:0]     skip_pc;
    logic [N_CORES-1:0]  ps_d;
    logic                ps_push;
    logic                ps_pop;
    logic                ps_comp;
    logic [N_CORES-1:0]  ps_q;
    logic                ps_all_false;
    logic [N_CORES-1:0]  lane_en;
    logic                pc_load;
    logic [PC_W-1:0]     pc_target;
    logic [DW-1:0]       depth;
    logic                err;

    modport slave (
        input  instr_valid, op, cond_mask, skip_pc, ps_q, ps_all_false,
        output instr_ready, ps_d, ps_push, ps_pop, ps_comp, lane_en,
               pc_load, pc_target, depth, err
    );

    modport master (
        output instr_valid, op, cond_mask, skip_pc, ps_q, ps_all_false,
        input  instr_ready, ps_d, ps_push, ps_pop, ps_comp, lane_en,
               pc_load, pc_target, depth, err
    );
endinterface

// File: rtl/divergence_ctrl.sv
// divergence_ctrl: turns decoded SIMT IF/ELSE/ENDIF ops into one-cycle
// push/comp/pop strobes for the predicate stack, requests a PC jump when the
// newly entered block has no active lane, and tracks nesting depth.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - divergence_ctrl_if.slave (handshake, pstack, PC request, status)
//
// state  | meaning
// IDLE   | ready for a new op
// STROBE | one strobe cycle to pstack (push / comp / pop)
// CHECK  | pstack top updated; jump over block if no lane active
module divergence_ctrl #(
    parameter int N_CORES = 4,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    divergence_ctrl_if.slave  bus
);
    localparam int DW = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_IF    = 2'd1;
    localparam logic [1:0] OP_ELSE  = 2'd2;
    localparam logic [1:0] OP_ENDIF = 2'd3;

    typedef enum logic [1:0] {IDLE, STROBE, CHECK} state_t;

    state_t              state, state_nxt;
    logic [1:0]          op_q;
    logic [PC_W-1:0]     skip_q;
    logic [PC_W-1:0]     target_q;
    logic [DW-1:0]       depth_q;
    logic                err_q;
    logic [N_CORES-1:0]  ps_d_q;
    logic [N_CORES-1:0]  lane_en_c;
    logic                pc_load_c;
    logic                accept;
    logic                op_ok;
    logic                op_bad;

    assign accept = bus.instr_valid && (state == IDLE);

    // op_ok: op issues a strobe; op_bad: op is consumed and only sets err
    always_comb begin
        op_ok  = 1'b0;
        op_bad = 1'b0;
        case (bus.op)
            OP_IF: begin
                op_ok  = (depth_q < DEPTH_MAX);
                op_bad = (depth_q >= DEPTH_MAX);
            end
            OP_ELSE, OP_ENDIF: begin
                op_ok  = (depth_q != '0);
                op_bad = (depth_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && op_ok) state_nxt = STROBE;
            STROBE:  state_nxt = (op_q == OP_ENDIF) ? IDLE : CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lane_en_c       = (depth_q != '0) ? bus.ps_q : '1;
        pc_load_c       = (state == CHECK) && bus.ps_all_false;
        bus.instr_ready = (state == IDLE);
        bus.ps_push     = (state == STROBE) && (op_q == OP_IF);
        bus.ps_comp     = (state == STROBE) && (op_q == OP_ELSE);
        bus.ps_pop      = (state == STROBE) && (op_q == OP_ENDIF);
        bus.ps_d        = ps_d_q;
        bus.lane_en     = lane_en_c;
        bus.pc_load     = pc_load_c;
        // target is presented combinationally with the request, then held
        bus.pc_target   = pc_load_c ? skip_q : target_q;
        bus.depth       = depth_q;
        bus.err         = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_NONE;
            skip_q   <= '0;
            target_q <= '0;
            depth_q  <= '0;
            err_q    <= 1'b0;
            ps_d_q   <= '0;
        end else begin
            if (accept) begin
                if (op_ok) begin
                    op_q   <= bus.op;
                    skip_q <= bus.skip_pc;
                    if (bus.op == OP_IF) ps_d_q <= bus.cond_mask & lane_en_c;
                end
                if (op_bad) err_q <= 1'b1;
            end
            if (state == STROBE) begin
                if (op_q == OP_IF)    depth_q <= depth_q + 1'b1;
                if (op_q == OP_ENDIF) depth_q <= depth_q - 1'b1;
            end
            if (pc_load_c) target_q <= skip_q;
        end
    end
endmodule

// File: tb/tb_divergence_ctrl.sv
module tb_divergence_ctrl;
    localparam int N  = 4;
    localparam int D  = 8;
    localparam int PW = 8;

    localparam logic [1:0] NONE_OP  = 2'd0;
    localparam logic [1:0] IF_OP    = 2'd1;
    localparam logic [1:0] ELSE_OP  = 2'd2;
    localparam logic [1:0] ENDIF_OP = 2'd3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    divergence_ctrl_if #(.N_CORES(N), .DEPTH(D), .PC_W(PW)) bus ();
    divergence_ctrl #(.N_CORES(N), .DEPTH(D), .PC_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // pstack environment: push d, complement top within parent, pop
    logic [N-1:0] ps_mem [0:D];
    int           ps_sp;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_sp <= 0;
        end else if (bus.ps_push && ps_sp <= D) begin
            ps_mem[ps_sp] <= bus.ps_d;
            ps_sp         <= ps_sp + 1;
        end else if (bus.ps_comp && ps_sp > 0) begin
            ps_mem[ps_sp-1] <= ~ps_mem[ps_sp-1] & ((ps_sp > 1) ? ps_mem[ps_sp-2] : 4'hF);
        end else if (bus.ps_pop && ps_sp > 0) begin
            ps_sp <= ps_sp - 1;
        end
    end
    assign bus.ps_q         = (ps_sp > 0) ? ps_mem[ps_sp-1] : 4'h0;
    assign bus.ps_all_false = (bus.ps_q == 4'h0);

    typedef struct {
        int           push, pop, comp;
        logic [N-1:0] psd;
        int           pcl;
        logic [PW-1:0] tgt_load, tgt_end;
        int           lat, depth;
        bit           err;
        logic [N-1:0] lane;
        bit           multi, idle_strobe;
    } vec_t;

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] mask;
        logic [PW-1:0] skip;
        vec_t         e;
    } tvec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // reference model: stack of active-lane masks, one entry per open IF
    logic [N-1:0]  m_stk[$];
    bit            m_err;
    logic [PW-1:0] m_tgt;

    task automatic m_reset();
        m_stk.delete();
        m_err = 0;
        m_tgt = '0;
    endtask

    task automatic model_step(input logic [1:0] o, input logic [N-1:0] mask,
                              input logic [PW-1:0] skip, output vec_t e);
        logic [N-1:0] cur, parent, nt;
        e = '{default: 0};
        cur = (m_stk.size() > 0) ? m_stk[$] : 4'hF;
        case (o)
            IF_OP: if (m_stk.size() < D) begin
                e.push = 1; e.psd = mask & cur; e.lat = 3;
                m_stk.push_back(mask & cur);
                if ((mask & cur) == 0) begin e.pcl = 1; e.tgt_load = skip; m_tgt = skip; end
            end else m_err = 1;
            ELSE_OP: if (m_stk.size() > 0) begin
                parent = (m_stk.size() > 1) ? m_stk[m_stk.size()-2] : 4'hF;
                nt = ~m_stk[$] & parent;
                m_stk[m_stk.size()-1] = nt;
                e.comp = 1; e.lat = 3;
                if (nt == 0) begin e.pcl = 1; e.tgt_load = skip; m_tgt = skip; end
            end else m_err = 1;
            ENDIF_OP: if (m_stk.size() > 0) begin
                void'(m_stk.pop_back());
                e.pop = 1; e.lat = 2;
            end else m_err = 1;
            default: ;
        endcase
        e.tgt_end = m_tgt;
        e.depth   = m_stk.size();
        e.err     = m_err;
        e.lane    = (m_stk.size() > 0) ? m_stk[$] : 4'hF;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [N-1:0] mask,
                          input logic [PW-1:0] skip, output vec_t r);
        int cyc;
        int s;
        r = '{default: 0};
        @(negedge clk);
        bus.instr_valid = 1'b1; bus.op = o; bus.cond_mask = mask; bus.skip_pc = skip;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0; bus.op = NONE_OP;
        cyc = 1;
        while (!bus.instr_ready && cyc < 12) begin
            s = int'(bus.ps_push) + int'(bus.ps_pop) + int'(bus.ps_comp);
            if (s > 1) r.multi = 1;
            if (bus.ps_push) begin r.push++; r.psd = bus.ps_d; end
            if (bus.ps_pop)  r.pop++;
            if (bus.ps_comp) r.comp++;
            if (bus.pc_load) begin r.pcl++; r.tgt_load = bus.pc_target; end
            @(posedge clk); #1;
            cyc++;
        end
        r.lat         = !bus.instr_ready ? -1 : (cyc == 1 ? 0 : cyc);
        r.idle_strobe = bus.ps_push | bus.ps_pop | bus.ps_comp | bus.pc_load;
        r.tgt_end     = bus.pc_target;
        r.depth       = int'(bus.depth);
        r.err         = bus.err;
        r.lane        = bus.lane_en;
    endtask

    task automatic cmp(input string tag, input vec_t r, input vec_t e);
        chk({tag, " push"}, r.push, e.push);
        chk({tag, " pop"},  r.pop,  e.pop);
        chk({tag, " comp"}, r.comp, e.comp);
        if (e.push != 0) chk({tag, " ps_d"}, r.psd, e.psd);
        chk({tag, " pc_load"}, r.pcl, e.pcl);
        if (e.pcl != 0) chk({tag, " pc_target"}, r.tgt_load, e.tgt_load);
        chk({tag, " pc_target_hold"}, r.tgt_end, e.tgt_end);
        chk({tag, " latency"}, r.lat, e.lat);
        chk({tag, " depth"}, r.depth, e.depth);
        chk({tag, " err"}, r.err, e.err);
        chk({tag, " lane_en"}, r.lane, e.lane);
        chk({tag, " strobe_overlap"}, r.multi, 0);
        chk({tag, " idle_strobe"}, r.idle_strobe, 0);
    endtask

    function automatic tvec_t mk(logic [1:0] o, logic [N-1:0] mask, logic [PW-1:0] skip,
                                 int push, int pop, int comp, logic [N-1:0] psd, int pcl,
                                 logic [PW-1:0] tl, logic [PW-1:0] te, int lat, int dep,
                                 logic [N-1:0] lane);
        tvec_t t;
        t.op = o; t.mask = mask; t.skip = skip;
        t.e = '{default: 0};
        t.e.push = push; t.e.pop = pop; t.e.comp = comp; t.e.psd = psd;
        t.e.pcl = pcl; t.e.tgt_load = tl; t.e.tgt_end = te; t.e.lat = lat;
        t.e.depth = dep; t.e.lane = lane;
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    tvec_t tbl[9];
    vec_t  r, e;
    int    pops;

    initial begin
        bus.instr_valid = 1'b0; bus.op = NONE_OP; bus.cond_mask = '0; bus.skip_pc = '0;
        reset = 1'b1;
        m_reset();
        #23;
        chk("reset ready",     bus.instr_ready, 1);
        chk("reset depth",     bus.depth, 0);
        chk("reset err",       bus.err, 0);
        chk("reset ps_d",      bus.ps_d, 0);
        chk("reset strobes",   {bus.ps_push, bus.ps_pop, bus.ps_comp}, 0);
        chk("reset pc_load",   bus.pc_load, 0);
        chk("reset pc_target", bus.pc_target, 0);
        chk("reset lane_en",   bus.lane_en, 4'hF);
        @(negedge clk); reset = 1'b0;

        // directed table
        tbl[0] = mk(IF_OP,    4'hA, 8'h20, 1,0,0, 4'hA, 0, 8'h00, 8'h00, 3, 1, 4'hA);
        tbl[1] = mk(IF_OP,    4'h0, 8'h30, 1,0,0, 4'h0, 1, 8'h30, 8'h30, 3, 2, 4'h0);
        tbl[2] = mk(ENDIF_OP, 4'h0, 8'h00, 0,1,0, 4'h0, 0, 8'h00, 8'h30, 2, 1, 4'hA);
        tbl[3] = mk(ELSE_OP,  4'h0, 8'h44, 0,0,1, 4'h0, 0, 8'h00, 8'h30, 3, 1, 4'h5);
        tbl[4] = mk(ENDIF_OP, 4'h0, 8'h00, 0,1,0, 4'h0, 0, 8'h00, 8'h30, 2, 0, 4'hF);
        tbl[5] = mk(IF_OP,    4'hF, 8'h40, 1,0,0, 4'hF, 0, 8'h00, 8'h30, 3, 1, 4'hF);
        tbl[6] = mk(ELSE_OP,  4'h0, 8'h50, 0,0,1, 4'h0, 1, 8'h50, 8'h50, 3, 1, 4'h0);
        tbl[7] = mk(ENDIF_OP, 4'h0, 8'h00, 0,1,0, 4'h0, 0, 8'h00, 8'h50, 2, 0, 4'hF);
        tbl[8] = mk(NONE_OP,  4'hF, 8'h77, 0,0,0, 4'h0, 0, 8'h00, 8'h50, 0, 0, 4'hF);
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].op, tbl[i].mask, tbl[i].skip, r);
            model_step(tbl[i].op, tbl[i].mask, tbl[i].skip, e);
            cmp($sformatf("tbl%0d", i), r, tbl[i].e);
        end

        // nest to the limit, overflow, then unwind
        do_reset();
        for (int i = 0; i < D; i++) begin
            logic [N-1:0] mk_mask;
            mk_mask = 4'(($urandom_range(0, 4) == 0) ? 0 : $urandom);
            run_op(IF_OP, mk_mask, 8'(8'h60 + i), r);
            model_step(IF_OP, mk_mask, 8'(8'h60 + i), e);
            cmp($sformatf("nest%0d", i), r, e);
        end
        run_op(IF_OP, 4'hF, 8'h99, r);
        model_step(IF_OP, 4'hF, 8'h99, e);
        chk("overflow push",  r.push, 0);
        chk("overflow err",   r.err, 1);
        chk("overflow depth", r.depth, D);
        pops = 0;
        for (int i = 0; i < D; i++) begin
            run_op(ENDIF_OP, 4'h0, 8'h00, r);
            model_step(ENDIF_OP, 4'h0, 8'h00, e);
            pops += r.pop;
        end
        chk("unwind pops",    pops, D);
        chk("unwind depth",   r.depth, 0);
        chk("unwind lane_en", r.lane, 4'hF);
        chk("unwind err",     r.err, 1);

        // underflow and NONE
        do_reset();
        run_op(ENDIF_OP, 4'h0, 8'h00, r);
        model_step(ENDIF_OP, 4'h0, 8'h00, e);
        chk("underflow pop", r.pop, 0);
        chk("underflow err", r.err, 1);
        chk("underflow latency", r.lat, 0);
        run_op(NONE_OP, 4'h3, 8'h11, r);
        model_step(NONE_OP, 4'h3, 8'h11, e);
        cmp("none", r, e);

        // reset during STROBE of an IF
        @(negedge clk);
        bus.instr_valid = 1'b1; bus.op = IF_OP; bus.cond_mask = 4'h6; bus.skip_pc = 8'h70;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0; bus.op = NONE_OP;
        chk("mid push before reset", bus.ps_push, 1);
        chk("mid err before reset",  bus.err, 1);
        reset = 1'b1; #1;
        chk("mid push after reset", bus.ps_push, 0);
        chk("mid depth",  bus.depth, 0);
        chk("mid err",    bus.err, 0);
        chk("mid ready",  bus.instr_ready, 1);
        @(negedge clk); reset = 1'b0;
        m_reset();
        @(posedge clk); #1;
        chk("mid depth settled", bus.depth, 0);
        chk("mid lane_en", bus.lane_en, 4'hF);

        // randomized ops against the model
        for (int i = 0; i < 300; i++) begin
            logic [1:0]    ro;
            logic [N-1:0]  rm;
            logic [PW-1:0] rs;
            if ($urandom_range(0, 99) == 0) do_reset();
            ro = 2'($urandom_range(0, 3));
            rm = 4'(($urandom_range(0, 3) == 0) ? 0 : $urandom);
            rs = 8'($urandom);
            run_op(ro, rm, rs, r);
            model_step(ro, rm, rs, e);
            cmp($sformatf("rnd%0d", i), r, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
